// File: rtl/neander_pkg.sv
// Shared Neander definitions: opcodes, control states and ULA codes.
// Used by the control unit, the datapath and the ULA.
package neander_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JN  = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ULA_ADD   = 3'd0;
  localparam logic [2:0] ULA_AND   = 3'd1;
  localparam logic [2:0] ULA_OR    = 3'd2;
  localparam logic [2:0] ULA_NOT   = 3'd3;
  localparam logic [2:0] ULA_PASSY = 3'd4;

  typedef enum logic [3:0] {
    S_F0   = 4'd0,
    S_F1   = 4'd1,
    S_F2   = 4'd2,
    S_DEC  = 4'd3,
    S_A0   = 4'd4,
    S_A1   = 4'd5,
    S_A2   = 4'd6,
    S_X0   = 4'd7,
    S_X1   = 4'd8,
    S_JP   = 4'd9,
    S_HALT = 4'd10
  } state_t;

  // Instructions that dereference their operand byte.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_STA) || (op == OP_LDA) || (op == OP_ADD) ||
           (op == OP_OR)  || (op == OP_AND);
  endfunction

  function automatic logic [2:0] ula_for(input logic [3:0] op);
    logic [2:0] r;
    r = ULA_PASSY;
    if (op == OP_ADD) r = ULA_ADD;
    if (op == OP_AND) r = ULA_AND;
    if (op == OP_OR)  r = ULA_OR;
    return r;
  endfunction

endpackage

// File: rtl/neander_control.sv
// Neander instruction sequencer: Moore FSM driving the datapath strobes.
// Fetch F0-F2, decode, operand fetch A0-A2, execute X0-X1, jump JP.
module neander_control
  import neander_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_opcode,
  input  logic       i_flag_n,
  input  logic       i_flag_z,
  output logic       o_pc_inc,
  output logic       o_pc_load,
  output logic       o_rem_sel,
  output logic       o_rem_load,
  output logic       o_mem_read,
  output logic       o_rdm_load,
  output logic       o_mem_write,
  output logic       o_ri_load,
  output logic       o_ac_load,
  output logic       o_nz_load,
  output logic [2:0] o_ula_op,
  output logic       o_halted,
  output logic [3:0] o_state
);

  state_t r_state;
  state_t w_next;
  logic   r_jump;
  logic   w_take;
  logic   w_skip;
  logic   w_mem;

  always_comb begin
    w_take = (i_opcode == OP_JMP) ||
             ((i_opcode == OP_JN) && i_flag_n) ||
             ((i_opcode == OP_JZ) && i_flag_z);
    w_skip = ((i_opcode == OP_JN) && !i_flag_n) ||
             ((i_opcode == OP_JZ) && !i_flag_z);
    w_mem  = is_mem_op(i_opcode);
  end

  // Branch decision is latched in DEC so later flag changes are ignored.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_F0;
      r_jump  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DEC) r_jump <= w_take;
    end
  end

  always_comb begin
    w_next = S_F0;
    unique case (r_state)
      S_F0: w_next = S_F1;
      S_F1: w_next = S_F2;
      S_F2: w_next = S_DEC;
      S_DEC: begin
        if (i_opcode == OP_HLT) w_next = S_HALT;
        else if (w_mem || w_take) w_next = S_A0;
        else w_next = S_F0;
      end
      S_A0: w_next = S_A1;
      S_A1: w_next = r_jump ? S_JP : S_A2;
      S_A2: w_next = S_X0;
      S_X0: w_next = (i_opcode == OP_STA) ? S_F0 : S_X1;
      S_X1: w_next = S_F0;
      S_JP: w_next = S_F0;
      S_HALT: w_next = S_HALT;
      default: w_next = S_F0;
    endcase
  end

  always_comb begin
    o_pc_inc    = 1'b0;
    o_pc_load   = 1'b0;
    o_rem_sel   = 1'b0;
    o_rem_load  = 1'b0;
    o_mem_read  = 1'b0;
    o_rdm_load  = 1'b0;
    o_mem_write = 1'b0;
    o_ri_load   = 1'b0;
    o_ac_load   = 1'b0;
    o_nz_load   = 1'b0;
    o_ula_op    = ULA_ADD;
    o_halted    = 1'b0;
    if (!i_rst) begin
      unique case (r_state)
        S_F0: o_rem_load = 1'b1;
        S_F1: begin
          o_mem_read = 1'b1;
          o_rdm_load = 1'b1;
          o_pc_inc   = 1'b1;
        end
        S_F2: o_ri_load = 1'b1;
        S_DEC: begin
          if (i_opcode == OP_NOT) begin
            o_ac_load = 1'b1;
            o_nz_load = 1'b1;
            o_ula_op  = ULA_NOT;
          end
          o_pc_inc = w_skip;
        end
        S_A0: o_rem_load = 1'b1;
        S_A1: begin
          o_mem_read = 1'b1;
          o_rdm_load = 1'b1;
          o_pc_inc   = w_mem;
        end
        S_A2: begin
          o_rem_sel  = 1'b1;
          o_rem_load = 1'b1;
        end
        S_X0: begin
          if (i_opcode == OP_STA) begin
            o_mem_write = 1'b1;
          end else begin
            o_mem_read = 1'b1;
            o_rdm_load = 1'b1;
          end
        end
        S_X1: begin
          o_ac_load = 1'b1;
          o_nz_load = 1'b1;
          o_ula_op  = ula_for(i_opcode);
        end
        S_JP: begin
          o_pc_inc  = 1'b1;
          o_pc_load = 1'b1;
        end
        S_HALT: o_halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign o_state = r_state;

endmodule
